pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised elastic pipeline register: a chain of STAGES registers, each WIDTH bits plus a valid bit, with valid/ready handshake, bubble propagation and a synchronous flush. It is the successor to the fixed-field inter-stage latches: one generic block instantiated between IF/ID/EX/MEM/WB with the control and data fields packed into in_data_i. Unlike the fixed latches it supports backpressure-driven stalls, multi-cycle depth and occupancy reporting.

Parameters:
WIDTH, 64, payload bits per stage (1..1024)
STAGES, 1, number of register stages in the chain (1..8)
CLEAR_ON_FLUSH, 1, 1 = flush also zeroes payload registers; 0 = flush clears valid bits only

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  reset, asynchronous, active-high
flush_i  input  1  synchronous kill of every in-flight entry
in_valid_i  input  1  upstream entry valid
in_data_i  input  WIDTH  upstream payload (packed control and data fields)
in_ready_o  output  1  block accepts in_data_i this cycle
out_valid_o  output  1  valid bit of the last stage
out_data_o  output  WIDTH  payload of the last stage
out_ready_i  input  1  downstream accepts out_data_o this cycle
count_o  output  $clog2(STAGES+1)  number of valid stages (registered)

Behaviour:
- Clock and reset: single clock CLK; reset RST is asynchronous and active-high.
- State: per-stage v[k] and d[k], k=0..STAGES-1. Stage 0 is fed by the input; stage STAGES-1 drives the outputs.
- Reset (async, any time, including mid-transfer): all v[k]=0, all d[k]=0, count_o=0. Consequently out_valid_o=0 and out_data_o=0; in_ready_o=1 once RST deasserts (if flush_i=0).
- Ready chain (combinational):
  - rdy[STAGES-1] = !v[STAGES-1] | out_ready_i
  - rdy[k] = !v[k] | rdy[k+1]
  - in_ready_o = rdy[0] & !flush_i
- Transfers: input fire = in_valid_i & in_ready_o; output fire = out_valid_o & out_ready_i.
- Normal edge (flush_i=0), for each k with rdy[k]=1:
  - v[k] <= source valid (in_valid_i for k=0, else v[k-1]).
  - d[k] <= source payload only when source valid = 1. On a bubble the payload is held, to save power.
- Normal edge, rdy[k]=0: stage holds v[k] and d[k] (stall).
- Flush edge (flush_i=1): all v[k] <= 0 and count_o <= 0.
  - Flush has priority over simultaneous input and output fires. The input is not accepted because in_ready_o=0.
  - An output fire in the flush cycle still counts as delivered downstream.
  - d[k] <= 0 if CLEAR_ON_FLUSH=1, else d[k] is held.
- Latency: an accepted entry appears on out_valid_o STAGES cycles after its input fire when no backpressure is present. Throughput is 1 entry/cycle.
- Full: count_o=STAGES and out_ready_i=0, which gives in_ready_o=0. Asserting out_ready_i makes in_ready_o=1 in the same cycle (pass-through ready; no skid).
- Empty: count_o=0, out_valid_o=0 and out_ready_i is ignored.
- count_o update: next = current + input fire − output fire, evaluated on the same edge; forced to 0 on flush. It never exceeds STAGES and never underflows.
- Ordering: entries leave in acceptance order, with no duplication or loss except on flush.

Optional Feature:
- Macro PIPE_PERF_EN.
- When defined, two extra outputs are added:
  - stall_cnt_o [31:0]: counts cycles with out_valid_o & !out_ready_i.
  - bubble_cnt_o [31:0]: counts cycles with !out_valid_o & !RST.
  - Both saturate at 32'hFFFF_FFFF.
  - Both are cleared by RST only; flush does not clear them.
  - Both are registered and update on the same edge as the pipeline.
- When undefined, these ports and their logic are absent and the port list is exactly as above.

Test Plan:
- STAGES=3, WIDTH=8, out_ready_i=1. Stream 8'h11, 8'h22, 8'h33 on consecutive cycles -> out_valid_o first high 3 cycles after the first fire; outputs 11, 22, 33 back-to-back; count_o peaks at 3.
- STAGES=3, out_ready_i=0. Offer 4 entries A1..A4 -> A1..A3 accepted, in_ready_o=0 with count_o=3, A4 held upstream. Raise out_ready_i -> in_ready_o=1 in the same cycle; order A1..A4 preserved.
- STAGES=2. Alternate in_valid_i 1/0 carrying 8'hAA then 8'hBB -> out_valid_o pattern 1,0,1 with a bubble in between; out_data_o holds AA during the bubble.
- STAGES=3, 3 valid entries, CLEAR_ON_FLUSH=1. Pulse flush_i with in_valid_i=1 and out_ready_i=1 -> in_ready_o=0 that cycle; next cycle count_o=0, out_valid_o=0, out_data_o=0; the head entry counts as delivered.
- Assert RST asynchronously mid-stream between edges -> out_valid_o, out_data_o and count_o go to 0 immediately, without waiting for CLK; first entry after release has full STAGES latency.
- PIPE_PERF_EN defined, STAGES=1. 5 cycles of out_valid_o=1 with out_ready_i=0, then 4 idle cycles -> stall_cnt_o=5, bubble_cnt_o counts idle cycles; preload to 32'hFFFF_FFFE -> stays at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline register: STAGES deep, WIDTH wide, with synchronous flush and occupancy count.
// Define PIPE_PERF_EN to add saturating stall/bubble cycle counters (stall_cnt_o, bubble_cnt_o).

module pipe_stage_reg_slot #(
  parameter int WIDTH          = 64,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush_i,
  input  logic             en_i,
  input  logic             src_valid_i,
  input  logic [WIDTH-1:0] src_data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);
  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush_i) begin
      v_d = 1'b0;
      if (CLEAR_ON_FLUSH != 0) d_d = '0;
    end else if (en_i) begin
      v_d = src_valid_i;
      // a bubble moves only the valid bit; the payload stays put to avoid toggling
      if (src_valid_i) d_d = src_data_i;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign valid_o = v_q;
  assign data_o  = d_q;
endmodule

module pipe_stage_reg #(
  parameter int WIDTH          = 64,
  parameter int STAGES         = 1,
  parameter int CLEAR_ON_FLUSH = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          flush_i,
  input  logic                          in_valid_i,
  input  logic [WIDTH-1:0]              in_data_i,
  output logic                          in_ready_o,
  output logic                          out_valid_o,
  output logic [WIDTH-1:0]              out_data_o,
  input  logic                          out_ready_i,
  output logic [$clog2(STAGES+1)-1:0]   count_o
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]                   stall_cnt_o,
  output logic [31:0]                   bubble_cnt_o
`endif
);
  localparam int CW = $clog2(STAGES+1);

  // index 0 is the upstream source, index k+1 is the output of stage k
  logic [STAGES:0]            vld_pipe;
  logic [STAGES:0][WIDTH-1:0] dat_pipe;
  logic [STAGES-1:0]          rdy;

  assign vld_pipe[0]   = in_valid_i;
  assign dat_pipe[0]   = in_data_i;
  assign rdy[STAGES-1] = !vld_pipe[STAGES] | out_ready_i;

  genvar k;
  for (k = 0; k < STAGES; k++) begin : g_stage
    if (k < STAGES-1) begin : g_rdy
      assign rdy[k] = !vld_pipe[k+1] | rdy[k+1];
    end
    pipe_stage_reg_slot #(
      .WIDTH         (WIDTH),
      .CLEAR_ON_FLUSH(CLEAR_ON_FLUSH)
    ) u_slot (
      .CLK        (CLK),
      .RST        (RST),
      .flush_i    (flush_i),
      .en_i       (rdy[k]),
      .src_valid_i(vld_pipe[k]),
      .src_data_i (dat_pipe[k]),
      .valid_o    (vld_pipe[k+1]),
      .data_o     (dat_pipe[k+1])
    );
  end

  logic          in_fire, out_fire;
  logic [CW-1:0] cnt_q, cnt_d;

  assign in_ready_o  = rdy[0] & !flush_i;
  assign out_valid_o = vld_pipe[STAGES];
  assign out_data_o  = dat_pipe[STAGES];
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = vld_pipe[STAGES] & out_ready_i;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i)                   cnt_d = '0;
    else if (in_fire && !out_fire) cnt_d = cnt_q + CW'(1);
    else if (!in_fire && out_fire) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

  // saturating; flush deliberately leaves both counters alone
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid_o && !out_ready_i && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (!out_valid_o && bubble_cnt_q != 32'hFFFF_FFFF)
      bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: STAGES=3 and STAGES=2 instances, plus STAGES=1 perf counters under PIPE_PERF_EN.

module tb_pipe_stage_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  // STAGES=3 instance
  logic       f3, iv3, ir3, ov3, or3;
  logic [7:0] id3, od3;
  logic [1:0] c3;
  logic [7:0] q3[$];

  pipe_stage_reg #(.WIDTH(8), .STAGES(3), .CLEAR_ON_FLUSH(1)) u_dut3 (
    .CLK(clk), .RST(rst), .flush_i(f3), .in_valid_i(iv3), .in_data_i(id3),
    .in_ready_o(ir3), .out_valid_o(ov3), .out_data_o(od3), .out_ready_i(or3),
    .count_o(c3)
`ifdef PIPE_PERF_EN
    , .stall_cnt_o(), .bubble_cnt_o()
`endif
  );

  // STAGES=2 instance
  logic       f2, iv2, ir2, ov2, or2;
  logic [7:0] id2, od2;
  logic [1:0] c2;
  logic [7:0] q2[$];

  pipe_stage_reg #(.WIDTH(8), .STAGES(2), .CLEAR_ON_FLUSH(1)) u_dut2 (
    .CLK(clk), .RST(rst), .flush_i(f2), .in_valid_i(iv2), .in_data_i(id2),
    .in_ready_o(ir2), .out_valid_o(ov2), .out_data_o(od2), .out_ready_i(or2),
    .count_o(c2)
`ifdef PIPE_PERF_EN
    , .stall_cnt_o(), .bubble_cnt_o()
`endif
  );

`ifdef PIPE_PERF_EN
  logic        f1, iv1, ir1, ov1, or1;
  logic [7:0]  id1, od1;
  logic [0:0]  c1;
  logic [31:0] sc1, bc1;

  pipe_stage_reg #(.WIDTH(8), .STAGES(1), .CLEAR_ON_FLUSH(1)) u_dut1 (
    .CLK(clk), .RST(rst), .flush_i(f1), .in_valid_i(iv1), .in_data_i(id1),
    .in_ready_o(ir1), .out_valid_o(ov1), .out_data_o(od1), .out_ready_i(or1),
    .count_o(c1), .stall_cnt_o(sc1), .bubble_cnt_o(bc1)
  );

  task automatic step1(input logic v, input logic [7:0] d, input logic o);
    @(posedge clk); #1;
    iv1 = v; id1 = d; or1 = o; f1 = 1'b0;
    @(negedge clk);
  endtask
`endif

  // monitors: pop and compare whenever an output transfer is presented
  always @(negedge clk) begin
    if (!rst && ov3 && or3) begin
      if (q3.size() == 0) begin
        checks++; errors++;
        $display("FAIL out3_unexpected got %h want none", od3);
      end else chk("out3_data", {24'd0, od3}, {24'd0, q3.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (!rst && ov2 && or2) begin
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL out2_unexpected got %h want none", od2);
      end else chk("out2_data", {24'd0, od2}, {24'd0, q2.pop_front()});
    end
  end

  // drive one cycle just after the edge, record acceptance at the following negedge
  task automatic step3(input logic v, input logic [7:0] d, input logic o, input logic f);
    @(posedge clk); #1;
    iv3 = v; id3 = d; or3 = o; f3 = f;
    @(negedge clk);
    if (iv3 && ir3) q3.push_back(d);
  endtask

  task automatic step2(input logic v, input logic [7:0] d, input logic o);
    @(posedge clk); #1;
    iv2 = v; id2 = d; or2 = o; f2 = 1'b0;
    @(negedge clk);
    if (iv2 && ir2) q2.push_back(d);
  endtask

  initial begin
    f3 = 0; iv3 = 0; id3 = 0; or3 = 0;
    f2 = 0; iv2 = 0; id2 = 0; or2 = 0;
`ifdef PIPE_PERF_EN
    f1 = 0; iv1 = 0; id1 = 0; or1 = 0;
`endif
    #2 rst = 1'b1;
    #1;
    chk("rst_ov3", {31'd0, ov3}, 32'd0);
    chk("rst_od3", {24'd0, od3}, 32'd0);
    chk("rst_cnt3", {30'd0, c3}, 32'd0);
    chk("rst_ov2", {31'd0, ov2}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_rst", {31'd0, ir3}, 32'd1);

    // streaming, no backpressure: 3-cycle latency, count peaks at 3
    step3(1, 8'h11, 1, 0); chk("t1_rdy", {31'd0, ir3}, 32'd1);
    step3(1, 8'h22, 1, 0); chk("t1_ov_n1", {31'd0, ov3}, 32'd0);
    step3(1, 8'h33, 1, 0); chk("t1_ov_n2", {31'd0, ov3}, 32'd0);
    step3(0, 8'h00, 1, 0); chk("t1_ov_n3", {31'd0, ov3}, 32'd1);
                           chk("t1_cnt_peak", {30'd0, c3}, 32'd3);
    step3(0, 8'h00, 1, 0); chk("t1_cnt_n4", {30'd0, c3}, 32'd2);
    step3(0, 8'h00, 1, 0);
    step3(0, 8'h00, 1, 0); chk("t1_empty", {31'd0, ov3}, 32'd0);
                           chk("t1_cnt0", {30'd0, c3}, 32'd0);

    // backpressure fill, then pass-through ready
    step3(1, 8'hA1, 0, 0);
    step3(1, 8'hA2, 0, 0);
    step3(1, 8'hA3, 0, 0);
    step3(1, 8'hA4, 0, 0); chk("t2_full_rdy", {31'd0, ir3}, 32'd0);
                           chk("t2_full_cnt", {30'd0, c3}, 32'd3);
    step3(1, 8'hA4, 0, 0); chk("t2_hold_rdy", {31'd0, ir3}, 32'd0);
    step3(1, 8'hA4, 1, 0); chk("t2_passthru_rdy", {31'd0, ir3}, 32'd1);
    repeat (4) step3(0, 8'h00, 1, 0);
    chk("t2_drained", q3.size(), 32'd0);

    // flush with simultaneous input and output fire
    step3(1, 8'hC1, 0, 0);
    step3(1, 8'hC2, 0, 0);
    step3(1, 8'hC3, 0, 0);
    step3(1, 8'hC4, 1, 1); chk("t3_flush_rdy", {31'd0, ir3}, 32'd0);
    step3(0, 8'h00, 1, 0); chk("t3_cnt", {30'd0, c3}, 32'd0);
                           chk("t3_ov", {31'd0, ov3}, 32'd0);
                           chk("t3_od", {24'd0, od3}, 32'd0);
                           chk("t3_dropped", q3.size(), 32'd2);
    q3.delete();

    // asynchronous reset between edges
    step3(1, 8'hD1, 1, 0);
    step3(1, 8'hD2, 1, 0);
    step3(1, 8'hD3, 1, 0);
    step3(1, 8'hD4, 1, 0); chk("t4_pre_ov", {31'd0, ov3}, 32'd1);
    #2 rst = 1'b1; iv3 = 1'b0;
    #1;
    chk("t4_async_ov", {31'd0, ov3}, 32'd0);
    chk("t4_async_od", {24'd0, od3}, 32'd0);
    chk("t4_async_cnt", {30'd0, c3}, 32'd0);
    q3.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    step3(1, 8'hE1, 1, 0);
    step3(0, 8'h00, 1, 0); chk("t4_lat_n1", {31'd0, ov3}, 32'd0);
    step3(0, 8'h00, 1, 0); chk("t4_lat_n2", {31'd0, ov3}, 32'd0);
    step3(0, 8'h00, 1, 0); chk("t4_lat_n3", {31'd0, ov3}, 32'd1);
    step3(0, 8'h00, 1, 0);
    chk("t4_drained", q3.size(), 32'd0);

    // bubble propagation on the 2-stage instance
    step2(1, 8'hAA, 1);
    step2(0, 8'h00, 1);
    step2(1, 8'hBB, 1); chk("t5_ov_a", {31'd0, ov2}, 32'd1);
    step2(0, 8'h00, 1); chk("t5_ov_bubble", {31'd0, ov2}, 32'd0);
                        chk("t5_od_hold", {24'd0, od2}, 32'h0000_00AA);
    step2(0, 8'h00, 1); chk("t5_ov_b", {31'd0, ov2}, 32'd1);
    step2(0, 8'h00, 1);
    chk("t5_drained", q2.size(), 32'd0);

`ifdef PIPE_PERF_EN
    begin
      logic [31:0] b7;
      @(negedge clk); #2 rst = 1'b1;
      @(negedge clk); #2 rst = 1'b0;
      step1(1, 8'h55, 0);
      step1(0, 8'h00, 0); chk("p_stall0", sc1, 32'd0);
      repeat (4) step1(0, 8'h00, 0);
      step1(0, 8'h00, 1); chk("p_stall5", sc1, 32'd5);
      step1(0, 8'h00, 0); b7 = bc1;
      repeat (4) step1(0, 8'h00, 0);
      chk("p_bubble4", bc1, b7 + 32'd4);
      chk("p_stall_keep", sc1, 32'd5);
      #1 u_dut1.bubble_cnt_q <= 32'hFFFF_FFFE;
      step1(0, 8'h00, 0); chk("p_sat1", bc1, 32'hFFFF_FFFF);
      step1(0, 8'h00, 0); chk("p_sat2", bc1, 32'hFFFF_FFFF);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
